// File: rtl/iter_alu.sv
// Multi-cycle ALU: single-cycle ALU ops plus iterative shift-add multiply and
// restoring divide into internal HI/LO registers, with MFHI/MFLO/MTHI/MTLO.
module iter_alu #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OP_W  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OP_W-1:0]  ALUOp,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Overflow,
    output logic             DivZero
);
    localparam int unsigned SH_W = $clog2(WIDTH);

    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_ADDU  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SUBU  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(5);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_NOR   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SLT   = OP_W'(8);
    localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(9);
    localparam logic [OP_W-1:0] OP_SLL   = OP_W'(10);
    localparam logic [OP_W-1:0] OP_SRL   = OP_W'(11);
    localparam logic [OP_W-1:0] OP_SRA   = OP_W'(12);
    localparam logic [OP_W-1:0] OP_SLLV  = OP_W'(13);
    localparam logic [OP_W-1:0] OP_SRLV  = OP_W'(14);
    localparam logic [OP_W-1:0] OP_SRAV  = OP_W'(15);
    localparam logic [OP_W-1:0] OP_LUI   = OP_W'(16);
    localparam logic [OP_W-1:0] OP_MULT  = OP_W'(17);
    localparam logic [OP_W-1:0] OP_MULTU = OP_W'(18);
    localparam logic [OP_W-1:0] OP_DIV   = OP_W'(19);
    localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(20);
    localparam logic [OP_W-1:0] OP_MFHI  = OP_W'(21);
    localparam logic [OP_W-1:0] OP_MFLO  = OP_W'(22);
    localparam logic [OP_W-1:0] OP_MTHI  = OP_W'(23);
    localparam logic [OP_W-1:0] OP_MTLO  = OP_W'(24);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, opnd_q, opnd_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, result_q, result_d;
    logic [SH_W-1:0]  cnt_q, cnt_d;
    logic             neg_q, neg_d, rneg_q, rneg_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             zero_q, zero_d, ovf_q, ovf_d, dz_q, dz_d;

    logic [WIDTH-1:0]   alu_res, sum, diff;
    logic               alu_ovf;
    logic [SH_W-1:0]    shamt;
    logic [WIDTH:0]     mul_sum, rem_sh, rem_try;
    logic [WIDTH-1:0]   mul_hi, mul_lo, div_hi, div_lo, quo_fix, rem_fix;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic               div_ok, last;
    logic               a_neg, b_neg, is_sgn, is_div;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               finish;

    // Single-cycle ops on the captured operands
    always_comb begin
        sum     = a_q + b_q;
        diff    = a_q - b_q;
        shamt   = a_q[SH_W-1:0];
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_ADDU: alu_res = sum;
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUBU:          alu_res = diff;
            OP_AND:           alu_res = a_q & b_q;
            OP_OR:            alu_res = a_q | b_q;
            OP_XOR:           alu_res = a_q ^ b_q;
            OP_NOR:           alu_res = ~(a_q | b_q);
            OP_SLT:           alu_res = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
            OP_SLTU:          alu_res = {{(WIDTH-1){1'b0}}, a_q < b_q};
            OP_SLL, OP_SLLV:  alu_res = b_q << shamt;
            OP_SRL, OP_SRLV:  alu_res = b_q >> shamt;
            OP_SRA, OP_SRAV:  alu_res = $unsigned($signed(b_q) >>> shamt);
            OP_LUI:           alu_res = {b_q[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            default:          alu_res = '0;
        endcase
    end

    // One multiply (shift-add) or divide (restoring) step on unsigned magnitudes
    always_comb begin
        mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        mul_hi   = mul_sum[WIDTH:1];
        mul_lo   = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        prod     = {mul_hi, mul_lo};
        prod_fix = neg_q ? -prod : prod;
        rem_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
        rem_try  = rem_sh - {1'b0, opnd_q};
        div_ok   = ~rem_try[WIDTH];
        div_hi   = div_ok ? rem_try[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        div_lo   = {acc_lo_q[WIDTH-2:0], div_ok};
        quo_fix  = neg_q ? -div_lo : div_lo;
        rem_fix  = rneg_q ? -div_hi : div_hi;
        last     = (cnt_q == SH_W'(WIDTH-1));
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        opnd_d   = opnd_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        ovf_d    = ovf_q;
        dz_d     = dz_q;
        finish   = 1'b0;
        is_sgn   = (ALUOp == OP_MULT) || (ALUOp == OP_DIV);
        is_div   = (ALUOp == OP_DIV) || (ALUOp == OP_DIVU);
        a_neg    = is_sgn & SrcA[WIDTH-1];
        b_neg    = is_sgn & SrcB[WIDTH-1];
        a_mag    = a_neg ? -SrcA : SrcA;
        b_mag    = b_neg ? -SrcB : SrcB;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_EXEC;
                    op_d     = ALUOp;
                    a_d      = SrcA;
                    b_d      = SrcB;
                    cnt_d    = '0;
                    acc_hi_d = '0;
                    acc_lo_d = is_div ? a_mag : b_mag;
                    opnd_d   = is_div ? b_mag : a_mag;
                    neg_d    = a_neg ^ b_neg;
                    rneg_d   = a_neg;
                    ovf_d    = 1'b0;
                    dz_d     = 1'b0;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_MULT, OP_MULTU: begin
                        acc_hi_d = mul_hi;
                        acc_lo_d = mul_lo;
                        cnt_d    = cnt_q + SH_W'(1);
                        if (last) begin
                            hi_d     = prod_fix[2*WIDTH-1:WIDTH];
                            lo_d     = prod_fix[WIDTH-1:0];
                            result_d = prod_fix[WIDTH-1:0];
                            finish   = 1'b1;
                        end
                    end
                    OP_DIV, OP_DIVU: begin
                        if (b_q == '0) begin
                            hi_d     = a_q;
                            lo_d     = '1;
                            result_d = '1;
                            dz_d     = 1'b1;
                            finish   = 1'b1;
                        end else begin
                            acc_hi_d = div_hi;
                            acc_lo_d = div_lo;
                            cnt_d    = cnt_q + SH_W'(1);
                            if (last) begin
                                hi_d     = rem_fix;
                                lo_d     = quo_fix;
                                result_d = quo_fix;
                                finish   = 1'b1;
                            end
                        end
                    end
                    OP_MFHI: begin
                        result_d = hi_q;
                        finish   = 1'b1;
                    end
                    OP_MFLO: begin
                        result_d = lo_q;
                        finish   = 1'b1;
                    end
                    OP_MTHI: begin
                        hi_d     = a_q;
                        result_d = a_q;
                        finish   = 1'b1;
                    end
                    OP_MTLO: begin
                        lo_d     = a_q;
                        result_d = a_q;
                        finish   = 1'b1;
                    end
                    default: begin
                        result_d = alu_res;
                        ovf_d    = alu_ovf;
                        finish   = 1'b1;
                    end
                endcase
                if (finish) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            opnd_q   <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            opnd_q   <= opnd_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            dz_q     <= dz_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign ALUResult = result_q;
    assign Zero      = zero_q;
    assign Overflow  = ovf_q;
    assign DivZero   = dz_q;

endmodule

// File: tb/tb_iter_alu.sv
// Bench for iter_alu: arithmetic reference model of results, HI/LO and latency,
// checked every cycle by one monitor, plus directed literal expectations.
module tb_iter_alu;
    localparam int unsigned W = 32;

    localparam logic [5:0] OP_ADD   = 6'd0;
    localparam logic [5:0] OP_ADDU  = 6'd1;
    localparam logic [5:0] OP_SUB   = 6'd2;
    localparam logic [5:0] OP_SUBU  = 6'd3;
    localparam logic [5:0] OP_AND   = 6'd4;
    localparam logic [5:0] OP_OR    = 6'd5;
    localparam logic [5:0] OP_XOR   = 6'd6;
    localparam logic [5:0] OP_NOR   = 6'd7;
    localparam logic [5:0] OP_SLT   = 6'd8;
    localparam logic [5:0] OP_SLTU  = 6'd9;
    localparam logic [5:0] OP_SLL   = 6'd10;
    localparam logic [5:0] OP_SRL   = 6'd11;
    localparam logic [5:0] OP_SRA   = 6'd12;
    localparam logic [5:0] OP_SLLV  = 6'd13;
    localparam logic [5:0] OP_SRLV  = 6'd14;
    localparam logic [5:0] OP_SRAV  = 6'd15;
    localparam logic [5:0] OP_LUI   = 6'd16;
    localparam logic [5:0] OP_MULT  = 6'd17;
    localparam logic [5:0] OP_MULTU = 6'd18;
    localparam logic [5:0] OP_DIV   = 6'd19;
    localparam logic [5:0] OP_DIVU  = 6'd20;
    localparam logic [5:0] OP_MFHI  = 6'd21;
    localparam logic [5:0] OP_MFLO  = 6'd22;
    localparam logic [5:0] OP_MTHI  = 6'd23;
    localparam logic [5:0] OP_MTLO  = 6'd24;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  ALUOp = '0;
    logic [31:0] SrcA = '0;
    logic [31:0] SrcB = '0;
    logic        busy, done, Zero, Overflow, DivZero;
    logic [31:0] ALUResult;

    iter_alu #(.WIDTH(32), .OP_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .ALUOp(ALUOp), .SrcA(SrcA), .SrcB(SrcB),
        .busy(busy), .done(done), .ALUResult(ALUResult), .Zero(Zero),
        .Overflow(Overflow), .DivZero(DivZero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          total = 0;
    int          bad = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    bit          mon_en = 1'b0;
    int          t_start = 0;
    int          t_done = 0;
    int          done_at = 0;
    logic [31:0] e_res = '0;
    logic        e_ovf = 1'b0;
    logic        e_dz = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Architectural meaning of each op; updates the model HI/LO
    task automatic model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic ovf, output logic dz, output int lat);
        longint      s, q, r;
        logic [63:0] p;
        res = '0; ovf = 1'b0; dz = 1'b0; lat = 2;
        case (op)
            OP_ADD: begin
                s = longint'($signed(a)) + longint'($signed(b));
                res = a + b;
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            OP_SUB: begin
                s = longint'($signed(a)) - longint'($signed(b));
                res = a - b;
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            OP_ADDU: res = a + b;
            OP_SUBU: res = a - b;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NOR:  res = ~(a | b);
            OP_SLT:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU: res = (a < b) ? 32'd1 : 32'd0;
            OP_SLL, OP_SLLV: res = b << a[4:0];
            OP_SRL, OP_SRLV: res = b >> a[4:0];
            OP_SRA, OP_SRAV: res = 32'($signed(b) >>> a[4:0]);
            OP_LUI:  res = {b[15:0], 16'h0000};
            OP_MULT: begin
                p = 64'(longint'($signed(a)) * longint'($signed(b)));
                m_hi = p[63:32]; m_lo = p[31:0]; res = p[31:0]; lat = W + 1;
            end
            OP_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                m_hi = p[63:32]; m_lo = p[31:0]; res = p[31:0]; lat = W + 1;
            end
            OP_DIV, OP_DIVU: begin
                if (b == 32'd0) begin
                    m_lo = 32'hFFFFFFFF; m_hi = a; res = m_lo; dz = 1'b1;
                end else begin
                    if (op == OP_DIV) begin
                        q = longint'($signed(a)) / longint'($signed(b));
                        r = longint'($signed(a)) % longint'($signed(b));
                        m_lo = q[31:0]; m_hi = r[31:0];
                    end else begin
                        m_lo = a / b; m_hi = a % b;
                    end
                    res = m_lo; lat = W + 1;
                end
            end
            OP_MFHI: res = m_hi;
            OP_MFLO: res = m_lo;
            OP_MTHI: begin m_hi = a; res = a; end
            OP_MTLO: begin m_lo = a; res = a; end
            default: res = '0;
        endcase
    endtask

    // Compare process: handshake every cycle, results once done has occurred
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check("busy", 32'(busy), 32'((cyc > t_start) && (cyc <= t_done)));
            check("done", 32'(done), 32'(cyc == t_done));
            if (done) done_at = cyc;
            if (cyc >= t_done) begin
                check("result", ALUResult, e_res);
                check("zero", 32'(Zero), 32'(e_res == 32'd0));
                check("overflow", 32'(Overflow), 32'(e_ovf));
                check("divzero", 32'(DivZero), 32'(e_dz));
            end else if (cyc > t_start) begin
                check("ovf_cleared", 32'(Overflow), 32'd0);
                check("dz_cleared", 32'(DivZero), 32'd0);
            end
        end
    end

    // Called at a negedge while idle; returns at the first idle cycle after done
    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, input bit hold);
        logic [31:0] r;
        logic        o, d;
        int          lat;
        model(op, a, b, r, o, d, lat);
        ALUOp = op; SrcA = a; SrcB = b; start = 1'b1;
        e_res = r; e_ovf = o; e_dz = d;
        t_start = cyc; t_done = cyc + lat; mon_en = 1'b1;
        @(negedge clk);
        if (hold) ALUOp = OP_ADD;
        else start = 1'b0;
        SrcA = $urandom; SrcB = $urandom;
        while (cyc < t_done) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic lit(input string name, input logic [31:0] exp);
        check(name, ALUResult, exp);
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            5: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [5:0] op;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", ALUResult, 32'd0);
        check("rst_zero", 32'(Zero), 32'd1);
        check("rst_ovf", 32'(Overflow), 32'd0);
        check("rst_dz", 32'(DivZero), 32'd0);

        issue(OP_ADD, 32'h7FFFFFFF, 32'h1, 1'b0);
        lit("add_ovf_res", 32'h80000000);
        check("add_ovf_flag", 32'(Overflow), 32'd1);
        check("add_lat", 32'(done_at - t_start), 32'd2);
        issue(OP_ADDU, 32'h7FFFFFFF, 32'h1, 1'b0);
        check("addu_noovf", 32'(Overflow), 32'd0);
        issue(OP_SRA, 32'd4, 32'h80000000, 1'b0);
        lit("sra", 32'hF8000000);
        issue(OP_SLTU, 32'hFFFFFFFF, 32'd1, 1'b0);
        lit("sltu", 32'd0);
        issue(OP_SLT, 32'hFFFFFFFF, 32'd1, 1'b0);
        lit("slt", 32'd1);

        issue(OP_MULT, 32'hFFFFFFFD, 32'd5, 1'b0);
        lit("mult_lo", 32'hFFFFFFF1);
        check("mult_lat", 32'(done_at - t_start), 32'd33);
        issue(OP_MFHI, 32'd0, 32'd0, 1'b0);
        lit("mult_hi", 32'hFFFFFFFF);
        issue(OP_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0);
        lit("multu_lo", 32'hFFFFFFFE);
        issue(OP_MFHI, 32'd0, 32'd0, 1'b0);
        lit("multu_hi", 32'd1);

        issue(OP_DIVU, 32'd100, 32'd7, 1'b0);
        lit("divu_q", 32'd14);
        issue(OP_MFHI, 32'd0, 32'd0, 1'b0);
        lit("divu_r", 32'd2);
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
        lit("div_q", 32'hFFFFFFFD);
        issue(OP_MFHI, 32'd0, 32'd0, 1'b0);
        lit("div_r", 32'hFFFFFFFF);
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        lit("div_ovf_q", 32'h80000000);
        issue(OP_MFHI, 32'd0, 32'd0, 1'b0);
        lit("div_ovf_r", 32'd0);
        issue(OP_DIV, 32'd5, 32'd0, 1'b0);
        lit("div0_lo", 32'hFFFFFFFF);
        check("div0_flag", 32'(DivZero), 32'd1);
        check("div0_lat", 32'(done_at - t_start), 32'd2);
        issue(OP_MFHI, 32'd0, 32'd0, 1'b0);
        lit("div0_hi", 32'd5);
        check("dz_clear_next", 32'(DivZero), 32'd0);

        issue(OP_MULT, 32'd123456, 32'hFFFF0001, 1'b1);
        issue(OP_MFHI, 32'd0, 32'd0, 1'b0);
        issue(OP_MFLO, 32'd0, 32'd0, 1'b0);

        issue(OP_MTLO, 32'h1234, 32'd0, 1'b0);
        ALUOp = OP_MULT; SrcA = 32'd7; SrcB = 32'd9; start = 1'b1;
        t_start = cyc; t_done = cyc + W + 1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        mon_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", ALUResult, 32'd0);
        check("abort_zero", 32'(Zero), 32'd1);
        rst = 1'b0;
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        issue(OP_MFLO, 32'd0, 32'd0, 1'b0);
        lit("mflo_after_rst", 32'd0);
        issue(OP_MFHI, 32'd0, 32'd0, 1'b0);
        lit("mfhi_after_rst", 32'd0);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) op = 6'($urandom_range(25, 63));
            else op = 6'($urandom_range(0, 24));
            issue(op, rnd_opnd(), rnd_opnd(), ($urandom_range(0, 7) == 0));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
